spi_rx_slave: RTL and testbench
===============================

// Module: spi_rx_slave
// PURPOSE
//  SPI receiver (slave end) for frames from the 64-bit SPI transmitter: ss_dec active-low, sck idle low, MSB first.
//  Oversamples ss_dec/sck/mosi on clk through synchronizers and shifts mosi in on each sck rising edge.
//  Frame closes on ss_dec rising: presents the last DATA_W bits and a one-cycle rx_valid strobe, or rx_err.
//  Sits at the capture side of the AES side-channel rig, feeding received plaintext/key words to the core.
// PARAMETERS
//  DATA_W          64    frame payload width; rx_data holds the last DATA_W bits shifted in
//  SYNC_STAGES     2     flops per input synchronizer (>=2)
//  TIMEOUT_CYCLES  4096  clk cycles with no sck rise in RECV before abort (only with SPI_RX_TIMEOUT_EN)
// PORTS
//  clk       in   1       system clock (50 MHz)
//  rst       in   1       synchronous, active-high reset
//  ss_dec    in   1       slave select, active low, async to clk
//  sck       in   1       serial clock, async to clk, idle low
//  mosi      in   1       serial data, stable around sck rise
//  rx_data   out  DATA_W  last accepted word; holds until next good frame
//  rx_valid  out  1       1-cycle pulse, rx_data updated same cycle
//  rx_err    out  1       1-cycle pulse: frame too short or aborted
//  rx_bits   out  12      sck rising edges in last closed frame, saturates at 4095
//  busy      out  1       high in RECV
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, rx_err=0, rx_bits=0, busy=0, shift reg=0, FSM=WAIT_IDLE.
//  - Inputs pass SYNC_STAGES flops; edges detected against one extra registered copy (ss_s, sck_s).
//  - FSM: WAIT_IDLE -> IDLE when ss_s=1. IDLE -> RECV on ss_s falling (clear shift reg, bit count=0).
//    RECV: each sck_s rise: shreg <= {shreg[DATA_W-2:0], mosi_s}; count++ (12-bit, saturating).
//    RECV -> IDLE on ss_s rising: count>=DATA_W -> rx_data<=shreg, rx_valid=1; else rx_err=1, rx_data held.
//    rx_bits <= count on every close (good or bad). busy=1 only in RECV.
//  - Extra leading edges (e.g. a dummy first bit) shift out: only the last DATA_W bits are kept.
//  - sck_s rise and ss_s rise in same cycle: edge shifted and counted first, close uses updated count/shreg.
//  - sck edges while ss_s high ignored. ss_s fall while in WAIT_IDLE ignored.
//  - Latency: rx_valid/rx_err asserted at clk edge SYNC_STAGES+2 after first clk edge sampling ss_dec high.
//  - rst mid-frame: outputs cleared, FSM to WAIT_IDLE; remainder of that frame discarded, no strobe.
//  - Input timing requirement: sck high and low each >= SYNC_STAGES+2 clk; ss_dec high >= SYNC_STAGES+2 clk.
//  - rx_valid and rx_err never both high; no strobes outside a close or abort event.
// CONFIGURATION
//  SPI_RX_TIMEOUT_EN defined: in RECV, idle counter counts clk since last sck_s rise (or ss_s fall);
//    reaching TIMEOUT_CYCLES -> rx_err pulse, rx_bits<=count, FSM to WAIT_IDLE (rest of frame discarded).
//  SPI_RX_TIMEOUT_EN undefined: no counter, RECV waits indefinitely; TIMEOUT_CYCLES unused.
// TESTING
//  1 Frame of 64 edges, data 0xDEADBEEF_01234567 MSB first, 24-clk sck phases -> rx_data=0xDEADBEEF01234567,
//    one rx_valid pulse, rx_bits=64, rx_err never high.
//  2 Same word preceded by one dummy 0 bit (65 edges) -> rx_data=0xDEADBEEF01234567, rx_bits=65.
//  3 Frame of 10 edges 0x3FF -> rx_err pulse, rx_valid 0, rx_data keeps prior 0xDEADBEEF01234567, rx_bits=10.
//  4 rst high 1 cycle after 20 edges, frame continues 44 edges -> no strobe; next 64-bit 0xA5A5A5A5_5A5A5A5A
//    frame -> rx_valid, rx_data=0xA5A5A5A55A5A5A5A.
//  5 Last sck rise coincident with ss_dec rise -> bit 0 captured, rx_valid, rx_bits=64; rx_valid at edge 4 (SYNC 2).
//  6 SPI_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: 30 edges then sck stalls 100 clk -> rx_err pulse, rx_bits=30,
//    busy=0; further edges before ss_dec rises ignored; without macro no pulse until ss_dec rises.

Source files
------------

// File: rtl/spi_rx_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_slave
// Description : SPI receiver, slave end. Frames use active-low ss_dec, sck
//               idle low, and MSB first. ss_dec, sck and mosi are
//               oversampled on clk through synchronizers. mosi is shifted in
//               on each sck rising edge. When ss_dec rises the frame closes:
//               the last DATA_W bits are presented with a one-cycle
//               rx_valid_o strobe, or a one-cycle rx_err_o strobe is raised
//               if the frame was too short.
// Ports       : clk        system clock
//               rst        synchronous, active-high reset
//               ss_dec_i   slave select, active low, async to clk
//               sck_i      serial clock, async to clk, idle low
//               mosi_i     serial data, stable around sck rise
//               rx_data_o  last accepted word, held until next good frame
//               rx_valid_o 1-cycle pulse, rx_data_o updated same cycle
//               rx_err_o   1-cycle pulse, frame too short or aborted
//               rx_bits_o  sck rises in last closed frame, saturating 4095
//               busy_o     high while receiving
// Options     : SPI_RX_TIMEOUT_EN - when defined, the receiver abandons a
//               frame after TIMEOUT_CYCLES clk cycles with no sck rise.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_slave #(
  parameter int DATA_W         = 64,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_dec_i,
  input  logic              sck_i,
  input  logic              mosi_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_err_o,
  output logic [11:0]       rx_bits_o,
  output logic              busy_o
);

  localparam logic [11:0] C_MIN_BITS = 12'(DATA_W);
  localparam logic [11:0] C_CNT_MAX  = 12'hFFF;

  // Reject configurations the synchronizers and counters cannot support.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || DATA_W < 2 || DATA_W > 4095) begin : g_bad_params
    $error("spi_rx_slave: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronizers. They are followed by one more registered stage
  // (*_s_q), and then by a delayed copy (*_d1_q) that edges are detected
  // against. mosi goes through the same depth, so mosi_s_q is aligned with
  // sck_s_q.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   ss_s_q;
  logic                   ss_d1_q;
  logic                   sck_s_q;
  logic                   sck_d1_q;
  logic                   mosi_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_s_q      <= 1'b0;
      ss_d1_q     <= 1'b0;
      sck_s_q     <= 1'b0;
      sck_d1_q    <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_dec_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_s_q      <= ss_sync_q[SYNC_STAGES-1];
      ss_d1_q     <= ss_s_q;
      sck_s_q     <= sck_sync_q[SYNC_STAGES-1];
      sck_d1_q    <= sck_s_q;
      mosi_s_q    <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  logic w_ss_rise;
  logic w_ss_fall;
  logic w_sck_rise;

  assign w_ss_rise  =  ss_s_q  & ~ss_d1_q;
  assign w_ss_fall  = ~ss_s_q  &  ss_d1_q;
  assign w_sck_rise =  sck_s_q & ~sck_d1_q;

  // --------------------------------------------------------------------------
  // Shift register and bit counter with the current sck edge already applied.
  // Because of this, a close in the same cycle as the last sck rise still
  // captures that bit.
  // --------------------------------------------------------------------------
  state_e              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   shreg_d;
  logic [11:0]         cnt_q;
  logic [11:0]         cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (w_sck_rise) begin
      shreg_d = {shreg_q[DATA_W-2:0], mosi_s_q};
      if (cnt_q != C_CNT_MAX) begin
        cnt_d = cnt_q + 12'd1;
      end
    end
  end

`ifdef SPI_RX_TIMEOUT_EN
  localparam int          C_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);
  logic [C_TO_W-1:0] idle_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Frame FSM with registered strobes and status.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      rx_bits_o  <= '0;
      busy_o     <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      rx_valid_o <= 1'b0;
      rx_err_o   <= 1'b0;
      case (state_q)
        // Wait until ss is seen high. A frame already in progress (for
        // example after a reset) is never joined part-way through.
        WAIT_IDLE: begin
          busy_o <= 1'b0;
          if (ss_s_q) begin
            state_q <= IDLE;
          end
        end

        IDLE: begin
          if (w_ss_fall) begin
            state_q <= RECV;
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end

        RECV: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_d;
          if (w_ss_rise) begin
            state_q   <= IDLE;
            busy_o    <= 1'b0;
            rx_bits_o <= cnt_d;
            if (cnt_d >= C_MIN_BITS) begin
              rx_data_o  <= shreg_d;
              rx_valid_o <= 1'b1;
            end else begin
              rx_err_o <= 1'b1;
            end
          end
`ifdef SPI_RX_TIMEOUT_EN
          else if (!w_sck_rise && idle_cnt_q == C_TO_LAST) begin
            // sck has stalled. The rest of this frame is dropped by
            // waiting for ss to go idle again.
            state_q   <= WAIT_IDLE;
            busy_o    <= 1'b0;
            rx_bits_o <= cnt_q;
            rx_err_o  <= 1'b1;
          end else if (w_sck_rise) begin
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
`endif
        end

        default: begin
          state_q <= WAIT_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_rx_slave
// Description : Directed self-checking bench for spi_rx_slave. It runs full
//               frames, a frame with a dummy leading bit, a short frame,
//               reset in the middle of a frame, a close coincident with the
//               last sck rise, and an sck stall (timeout option).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_rx_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss_dec = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [11:0] rx_bits;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int valid_total = 0;
  int err_total = 0;
  int both_total = 0;

  always #10 clk = ~clk;

  spi_rx_slave #(
    .DATA_W        (64),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_dec_i  (ss_dec),
    .sck_i     (sck),
    .mosi_i    (mosi),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .rx_err_o  (rx_err),
    .rx_bits_o (rx_bits),
    .busy_o    (busy)
  );

  // Strobe monitor: the pulse counters only ever increase. Tests compare
  // deltas taken across each scenario.
  always @(negedge clk) begin
    if (rx_valid) valid_total++;
    if (rx_err) err_total++;
    if (rx_valid && rx_err) both_total++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    sck = 1'b0;
    ss_dec = 1'b0;
    clk_wait(24);
  endtask

  // Send the low n bits of w, MSB first, with 24-clk sck phases.
  task automatic send_bits(input logic [127:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sck = 1'b0;
      mosi = w[i];
      clk_wait(24);
      sck = 1'b1;
      clk_wait(24);
    end
  endtask

  task automatic end_frame();
    sck = 1'b0;
    clk_wait(24);
    ss_dec = 1'b1;
    clk_wait(30);
  endtask

  task automatic test_reset();
    clk_wait(3);
    checks++; if (rx_data !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", rx_data); end
    checks++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", rx_valid, rx_err); end
    checks++; if (rx_bits !== 12'd0) begin errors++; $display("FAIL reset_bits got=%0d exp=0", rx_bits); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    clk_wait(10);
  endtask

  task automatic test_full_frame();
    int v0, e0;
    v0 = valid_total; e0 = err_total;
    start_frame();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b exp=1", busy); end
    send_bits(128'hDEADBEEF_01234567, 64);
    end_frame();
    checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL full_valid_pulses got=%0d exp=1", valid_total - v0); end
    checks++; if (err_total - e0 !== 0) begin errors++; $display("FAIL full_err_pulses got=%0d exp=0", err_total - e0); end
    checks++; if (rx_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL full_data got=%h exp=deadbeef01234567", rx_data); end
    checks++; if (rx_bits !== 12'd64) begin errors++; $display("FAIL full_bits got=%0d exp=64", rx_bits); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_dummy_bit();
    int v0;
    v0 = valid_total;
    start_frame();
    send_bits({63'h0, 1'b0, 64'hDEADBEEF_01234567}, 65);
    end_frame();
    checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL dummy_valid_pulses got=%0d exp=1", valid_total - v0); end
    checks++; if (rx_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL dummy_data got=%h exp=deadbeef01234567", rx_data); end
    checks++; if (rx_bits !== 12'd65) begin errors++; $display("FAIL dummy_bits got=%0d exp=65", rx_bits); end
  endtask

  task automatic test_short_frame();
    int v0, e0;
    v0 = valid_total; e0 = err_total;
    start_frame();
    send_bits(128'h3FF, 10);
    end_frame();
    checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL short_err_pulses got=%0d exp=1", err_total - e0); end
    checks++; if (valid_total - v0 !== 0) begin errors++; $display("FAIL short_valid_pulses got=%0d exp=0", valid_total - v0); end
    checks++; if (rx_data !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL short_data_held got=%h exp=deadbeef01234567", rx_data); end
    checks++; if (rx_bits !== 12'd10) begin errors++; $display("FAIL short_bits got=%0d exp=10", rx_bits); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    v0 = valid_total; e0 = err_total;
    start_frame();
    send_bits(128'hFFFFF, 20);
    rst = 1'b1;
    clk_wait(1);
    rst = 1'b0;
    clk_wait(1);
    checks++; if (rx_data !== 64'h0) begin errors++; $display("FAIL midrst_data got=%h exp=0", rx_data); end
    checks++; if (rx_bits !== 12'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_status got=bits%0d busy%b exp=bits0 busy0", rx_bits, busy); end
    send_bits(128'h0FFF_FFFFFFFF, 44);
    end_frame();
    checks++; if (valid_total - v0 !== 0 || err_total - e0 !== 0) begin errors++; $display("FAIL midrst_no_strobe got=v%0d e%0d exp=v0 e0", valid_total - v0, err_total - e0); end
    start_frame();
    send_bits(128'hA5A5A5A5_5A5A5A5A, 64);
    end_frame();
    checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid got=%0d exp=1", valid_total - v0); end
    checks++; if (rx_data !== 64'hA5A5A5A5_5A5A5A5A) begin errors++; $display("FAIL midrst_next_data got=%h exp=a5a5a5a55a5a5a5a", rx_data); end
  endtask

  task automatic test_coincident_close();
    logic [127:0] w;
    int v0;
    w = 128'h01234567_89ABCDEF;
    v0 = valid_total;
    start_frame();
    send_bits(w >> 1, 63);
    sck = 1'b0;
    mosi = w[0];
    clk_wait(24);
    sck = 1'b1;
    ss_dec = 1'b1;
    clk_wait(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL coinc_early got=%b exp=0 at edge3", rx_valid); end
    clk_wait(1);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL coinc_latency got=%b exp=1 at edge4", rx_valid); end
    clk_wait(1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL coinc_pulse_width got=%b exp=0 at edge5", rx_valid); end
    checks++; if (rx_data !== 64'h01234567_89ABCDEF) begin errors++; $display("FAIL coinc_data got=%h exp=0123456789abcdef", rx_data); end
    checks++; if (rx_bits !== 12'd64) begin errors++; $display("FAIL coinc_bits got=%0d exp=64", rx_bits); end
    checks++; if (valid_total - v0 !== 1) begin errors++; $display("FAIL coinc_valid_pulses got=%0d exp=1", valid_total - v0); end
    sck = 1'b0;
    clk_wait(30);
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = valid_total; e0 = err_total;
    start_frame();
    send_bits(128'h2AAAAAAA, 30);
    sck = 1'b0;
    clk_wait(150);
`ifdef SPI_RX_TIMEOUT_EN
    checks++; if (err_total - e0 !== 1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_total - e0); end
    checks++; if (rx_bits !== 12'd30) begin errors++; $display("FAIL timeout_bits got=%0d exp=30", rx_bits); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    send_bits(128'h1F, 5);
    end_frame();
    checks++; if (err_total - e0 !== 1 || valid_total - v0 !== 0) begin errors++; $display("FAIL timeout_ignored got=e%0d v%0d exp=e1 v0", err_total - e0, valid_total - v0); end
`else
    checks++; if (err_total - e0 !== 0) begin errors++; $display("FAIL stall_no_err got=%0d exp=0", err_total - e0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b exp=1", busy); end
    end_frame();
    checks++; if (err_total - e0 !== 1 || valid_total - v0 !== 0) begin errors++; $display("FAIL stall_close got=e%0d v%0d exp=e1 v0", err_total - e0, valid_total - v0); end
    checks++; if (rx_bits !== 12'd30) begin errors++; $display("FAIL stall_bits got=%0d exp=30", rx_bits); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_dummy_bit();
    test_short_frame();
    test_reset_mid_frame();
    test_coincident_close();
    test_timeout();
    checks++; if (both_total !== 0) begin errors++; $display("FAIL strobes_exclusive got=%0d exp=0", both_total); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
